// File: rtl/tx_polyphase_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_polyphase_fir_pkg
// Description : Shared symbol encoding, width helpers and quantiser constants
//               for the polyphase transmit pulse-shaping filter.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_polyphase_fir_pkg;

    // Each tap holds a mapped symbol; SYM_ZERO is the underrun filler.
    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b11
    } sym_t;

    localparam logic c_BIT_POS = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int nb_coeff, input int nbauds);
        return nb_coeff + clog2(nbauds) + 1;
    endfunction

    function automatic int quant_drop(input int nbf_coeff, input int nbf_output);
        return nbf_coeff - nbf_output;
    endfunction

    function automatic sym_t map_sym(input logic valid, input logic bit_in);
        if (!valid) return SYM_ZERO;
        return (bit_in == c_BIT_POS) ? SYM_POS : SYM_NEG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fir_quant.sv
`default_nettype none
// ============================================================================
// Module      : tx_fir_quant
// Description : Round-half-up LSB drop followed by saturation to NB_OUT bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fir_quant #(
    parameter int NB_IN  = 12,
    parameter int NB_OUT = 8,
    parameter int N_DROP = 0
) (
    input  logic signed [NB_IN-1:0]  i_data,
    output logic signed [NB_OUT-1:0] o_data
);
    localparam logic signed [NB_IN:0] c_MAX = (NB_IN+1)'((1 << (NB_OUT-1)) - 1);
    localparam logic signed [NB_IN:0] c_MIN = ~c_MAX;

    logic signed [NB_IN:0] w_ext;
    logic signed [NB_IN:0] w_rnd;

    // One guard bit keeps the rounding add from wrapping.
    assign w_ext = {i_data[NB_IN-1], i_data};

    if (N_DROP > 0) begin : g_round
        localparam logic signed [NB_IN:0] c_HALF = (NB_IN+1)'(1 << (N_DROP-1));
        logic signed [NB_IN:0] w_sum;
        assign w_sum = w_ext + c_HALF;
        assign w_rnd = w_sum >>> N_DROP;
    end else begin : g_pass
        assign w_rnd = w_ext;
    end

    always_comb begin
        if (w_rnd > c_MAX)      o_data = c_MAX[NB_OUT-1:0];
        else if (w_rnd < c_MIN) o_data = c_MIN[NB_OUT-1:0];
        else                    o_data = w_rnd[NB_OUT-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/tx_polyphase_fir.sv
`default_nettype none
// ============================================================================
// Module      : tx_polyphase_fir
// Description : Multi-channel polyphase interpolating FIR for +/-1 symbols
//               with a writable shared coefficient bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_polyphase_fir
    import tx_polyphase_fir_pkg::*;
#(
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 6,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 6,
    parameter int NBAUDS     = 6,
    parameter int OS         = 4,
    parameter int NCH        = 2
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic [NCH-1:0]              i_sym,
    output logic                        o_ready,
    input  logic                        i_coeff_we,
    input  logic [clog2(NBAUDS*OS)-1:0] i_coeff_addr,
    input  logic [NB_COEFF-1:0]         i_coeff_data,
    output logic [NCH*NB_OUTPUT-1:0]    o_data,
    output logic                        o_valid,
    output logic [clog2(OS)-1:0]        o_phase,
    output logic                        o_underrun
);
    localparam int c_NTAPS  = NBAUDS * OS;
    localparam int c_ADDR_W = clog2(c_NTAPS);
    localparam int c_PH_W   = clog2(OS);
    localparam int c_ACC_W  = acc_width(NB_COEFF, NBAUDS);
    localparam int c_DROP   = quant_drop(NBF_COEFF, NBF_OUTPUT);
    localparam logic [c_PH_W-1:0] c_LAST_PH = c_PH_W'(OS - 1);

    logic signed [NB_COEFF-1:0] r_coeff [c_NTAPS];
    sym_t                       r_taps  [NCH][NBAUDS];
    logic [c_PH_W-1:0]          r_phase;
    logic                       r_underrun;
    logic [NCH*NB_OUTPUT-1:0]   r_data;
    logic                       r_valid;
    logic [c_PH_W-1:0]          r_out_phase;

    logic                       w_last;
    logic                       w_wrap;
    logic                       w_coeff_wr;
    logic signed [NB_COEFF-1:0] w_phase_coeff [NBAUDS];
    logic [NCH*NB_OUTPUT-1:0]   w_q;

    assign w_last     = (r_phase == c_LAST_PH);
    assign w_wrap     = i_enable && w_last;
    assign w_coeff_wr = i_coeff_we && (32'(i_coeff_addr) < 32'(c_NTAPS));

    // Sub-filter for the current phase: h[k*OS + p], shared by all channels.
    for (genvar k = 0; k < NBAUDS; k++) begin : g_tap
        assign w_phase_coeff[k] = r_coeff[c_ADDR_W'(k * OS) + c_ADDR_W'(r_phase)];
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [c_ACC_W-1:0] w_acc;

        always_comb begin
            w_acc = '0;
            for (int k = 0; k < NBAUDS; k++) begin
                case (r_taps[c][k])
                    SYM_POS: w_acc = w_acc + c_ACC_W'(w_phase_coeff[k]);
                    SYM_NEG: w_acc = w_acc - c_ACC_W'(w_phase_coeff[k]);
                    default: ;
                endcase
            end
        end

        tx_fir_quant #(
            .NB_IN  (c_ACC_W),
            .NB_OUT (NB_OUTPUT),
            .N_DROP (c_DROP)
        ) u_quant (
            .i_data (w_acc),
            .o_data (w_q[c*NB_OUTPUT +: NB_OUTPUT])
        );
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_phase     <= '0;
            r_underrun  <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_out_phase <= '0;
            for (int n = 0; n < c_NTAPS; n++) r_coeff[n] <= '0;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NBAUDS; k++) r_taps[c][k] <= SYM_ZERO;
            end
        end else begin
            r_valid <= i_enable;
            if (i_enable) begin
                r_phase     <= w_last ? '0 : r_phase + 1'b1;
                r_data      <= w_q;
                r_out_phase <= r_phase;
            end
            // The wrap output above still uses the pre-shift history.
            if (w_wrap) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int k = NBAUDS - 1; k > 0; k--) r_taps[c][k] <= r_taps[c][k-1];
                    r_taps[c][0] <= map_sym(i_valid, i_sym[c]);
                end
                if (!i_valid) r_underrun <= 1'b1;
            end
            if (w_coeff_wr) r_coeff[i_coeff_addr] <= i_coeff_data;
        end
    end

    assign o_ready    = w_last;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_phase    = r_out_phase;
    assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tx_polyphase_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_polyphase_fir
// Description : Self-checking bench with an arithmetic reference model; runs
//               a full-precision instance and a 5-fractional-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_polyphase_fir;
    localparam int OS     = 4;
    localparam int NBAUDS = 6;
    localparam int NTAPS  = 24;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic [1:0]  i_sym;
    logic        i_coeff_we;
    logic [4:0]  i_coeff_addr;
    logic [7:0]  i_coeff_data;

    logic [15:0] o_data_a,  o_data_b;
    logic        o_valid_a, o_valid_b;
    logic [1:0]  o_phase_a, o_phase_b;
    logic        o_underrun_a, o_underrun_b;
    logic        o_ready_a, o_ready_b;

    tx_polyphase_fir dut_a (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_sym(i_sym), .o_ready(o_ready_a), .i_coeff_we(i_coeff_we),
        .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
        .o_data(o_data_a), .o_valid(o_valid_a), .o_phase(o_phase_a),
        .o_underrun(o_underrun_a)
    );

    tx_polyphase_fir #(.NBF_OUTPUT(5)) dut_b (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_sym(i_sym), .o_ready(o_ready_b), .i_coeff_we(i_coeff_we),
        .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
        .o_data(o_data_b), .o_valid(o_valid_b), .o_phase(o_phase_b),
        .o_underrun(o_underrun_b)
    );

    wire [20:0] act_a = {o_data_a, o_valid_a, o_phase_a, o_underrun_a, o_ready_a};
    wire [20:0] act_b = {o_data_b, o_valid_b, o_phase_b, o_underrun_b, o_ready_b};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: symbol history as +1/-1/0, coefficients as ints.
    int m_hist [2][NBAUDS];
    int m_h    [NTAPS];
    int m_out  [2][2];
    int m_phase, m_ophase;
    bit m_valid, m_underrun;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int quant(input int acc, input int drop);
        int r;
        r = (drop > 0) ? ((acc + (1 << (drop - 1))) >>> drop) : acc;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic [20:0] exp_vec(input int d);
        return {8'(m_out[d][1]), 8'(m_out[d][0]), m_valid, 2'(m_ophase),
                m_underrun, (m_phase == OS - 1)};
    endfunction

    task automatic tick(input bit rst_n, input bit en, input bit vld, input bit [1:0] sym,
                        input bit we, input bit [4:0] addr, input bit [7:0] data);
        int acc;
        i_reset = rst_n; i_enable = en; i_valid = vld; i_sym = sym;
        i_coeff_we = we; i_coeff_addr = addr; i_coeff_data = data;
        if (!rst_n) begin
            m_phase = 0; m_ophase = 0; m_valid = 0; m_underrun = 0;
            for (int n = 0; n < NTAPS; n++) m_h[n] = 0;
            for (int c = 0; c < 2; c++) begin
                m_out[0][c] = 0; m_out[1][c] = 0;
                for (int k = 0; k < NBAUDS; k++) m_hist[c][k] = 0;
            end
        end else begin
            if (en) begin
                for (int c = 0; c < 2; c++) begin
                    acc = 0;
                    for (int k = 0; k < NBAUDS; k++) acc += m_hist[c][k] * m_h[k*OS + m_phase];
                    m_out[0][c] = quant(acc, 0);
                    m_out[1][c] = quant(acc, 1);
                end
                m_valid = 1; m_ophase = m_phase;
                if (m_phase == OS - 1) begin
                    for (int c = 0; c < 2; c++) begin
                        for (int k = NBAUDS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                        m_hist[c][0] = vld ? (sym[c] ? -1 : 1) : 0;
                    end
                    if (!vld) m_underrun = 1;
                end
                m_phase = (m_phase + 1) % OS;
            end else begin
                m_valid = 0;
            end
            if (we && addr < NTAPS) m_h[addr] = int'($signed(data));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run(input bit en, input bit vld, input bit [1:0] sym);
        tick(1, en, vld, sym, 0, 5'd0, 8'd0);
    endtask

    task automatic wr(input bit [4:0] addr, input bit [7:0] data);
        tick(1, 0, 0, 2'b00, 1, addr, data);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 2'b11, 1, 5'(i), 8'h55);
        n_cmp++;
        if (act_a !== 21'h0) begin
            n_err++; $display("FAIL reset_a: got %h expected %h", act_a, 21'h0);
        end
        n_cmp++;
        if (act_b !== 21'h0) begin
            n_err++; $display("FAIL reset_b: got %h expected %h", act_b, 21'h0);
        end
    endtask

    task automatic test_impulse;
        tick(0, 0, 0, 2'b00, 0, 5'd0, 8'd0);
        for (int n = 0; n < NTAPS; n++) wr(5'(n), 8'(n));
        for (int i = 0; i < 3; i++) run(1, 0, 2'b00);
        run(1, 1, 2'b10);
        for (int n = 0; n < NTAPS + 4; n++) begin
            run(1, 0, 2'b00);
            n_cmp++;
            if (o_data_a[7:0] !== 8'((n < NTAPS) ? n : 0) || o_data_a[15:8] !== 8'((n < NTAPS) ? -n : 0)) begin
                n_err++;
                $display("FAIL impulse[%0d]: got %h expected %h", n, o_data_a,
                         {8'((n < NTAPS) ? -n : 0), 8'((n < NTAPS) ? n : 0)});
            end
            n_cmp++;
            if (act_b !== exp_vec(1)) begin
                n_err++; $display("FAIL impulse_b[%0d]: got %h expected %h", n, act_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_saturation;
        tick(0, 0, 0, 2'b00, 0, 5'd0, 8'd0);
        for (int n = 0; n < NTAPS; n++) wr(5'(n), 8'h7F);
        for (int i = 0; i < NTAPS + 1; i++) run(1, 1, 2'b00);
        n_cmp++;
        if (o_data_a !== 16'h7F7F || o_data_b !== 16'h7F7F) begin
            n_err++; $display("FAIL sat_pos: got %h/%h expected 7f7f", o_data_a, o_data_b);
        end
        for (int i = 0; i < NTAPS; i++) begin
            run(1, 1, 2'b11);
            n_cmp++;
            if (act_a !== exp_vec(0)) begin
                n_err++; $display("FAIL sat_walk[%0d]: got %h expected %h", i, act_a, exp_vec(0));
            end
        end
        n_cmp++;
        if (o_data_a !== 16'h8080 || o_phase_a !== 2'd0) begin
            n_err++; $display("FAIL sat_neg: got %h ph %0d expected 8080 ph 0", o_data_a, o_phase_a);
        end
    endtask

    task automatic test_rounding;
        bit [7:0] coef [2] = '{8'h03, 8'hFD};
        bit [7:0] want [2] = '{8'h02, 8'hFF};
        for (int j = 0; j < 2; j++) begin
            tick(0, 0, 0, 2'b00, 0, 5'd0, 8'd0);
            wr(5'd0, coef[j]);
            for (int i = 0; i < 3; i++) run(1, 1, 2'b00);
            run(1, 1, 2'b00);
            run(1, 1, 2'b00);
            n_cmp++;
            if (o_data_b[7:0] !== want[j] || o_data_b[15:8] !== want[j] || o_phase_b !== 2'd0) begin
                n_err++;
                $display("FAIL round[%0d]: got %h ph %0d expected %h ph 0", j, o_data_b, o_phase_b, want[j]);
            end
            n_cmp++;
            if (o_data_a[7:0] !== coef[j]) begin
                n_err++; $display("FAIL round_full[%0d]: got %h expected %h", j, o_data_a[7:0], coef[j]);
            end
        end
    endtask

    task automatic test_underrun;
        tick(0, 0, 0, 2'b00, 0, 5'd0, 8'd0);
        for (int n = 0; n < NTAPS; n++) wr(5'(n), 8'($urandom));
        for (int i = 0; i < 8; i++) run(1, 1, 2'($urandom));
        n_cmp++;
        if (o_underrun_a !== 1'b0) begin
            n_err++; $display("FAIL underrun_clear: got %b expected 0", o_underrun_a);
        end
        for (int i = 0; i < 3; i++) run(1, 1, 2'($urandom));
        run(1, 0, 2'b11);
        n_cmp++;
        if (o_underrun_a !== 1'b1 || o_underrun_b !== 1'b1) begin
            n_err++; $display("FAIL underrun_set: got %b/%b expected 1", o_underrun_a, o_underrun_b);
        end
        for (int i = 0; i < 16; i++) begin
            run(1, 1, 2'($urandom));
            n_cmp++;
            if (act_a !== exp_vec(0) || act_b !== exp_vec(1)) begin
                n_err++;
                $display("FAIL underrun_hold[%0d]: got %h/%h expected %h/%h", i, act_a, act_b,
                         exp_vec(0), exp_vec(1));
            end
        end
    endtask

    task automatic test_enable_gaps;
        tick(0, 0, 0, 2'b00, 0, 5'd0, 8'd0);
        for (int n = 0; n < NTAPS; n++) wr(5'(n), 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            tick(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0), 2'($urandom),
                 ($urandom_range(0, 7) == 0), 5'($urandom), 8'($urandom));
            n_cmp++;
            if (act_a !== exp_vec(0) || act_b !== exp_vec(1)) begin
                n_err++;
                $display("FAIL gaps[%0d]: got %h/%h expected %h/%h", i, act_a, act_b,
                         exp_vec(0), exp_vec(1));
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < NTAPS; n++) wr(5'(n), 8'($urandom));
        for (int i = 0; i < 40 && m_phase != 2; i++) run(1, 1, 2'($urandom));
        for (int i = 0; i < 4; i++) run(1, 1, 2'($urandom));
        for (int i = 0; i < 4 && m_phase != 2; i++) run(1, 1, 2'($urandom));
        tick(0, 1, 1, 2'b00, 0, 5'd0, 8'd0);
        n_cmp++;
        if (act_a !== 21'h0 || act_b !== 21'h0) begin
            n_err++; $display("FAIL reset_mid: got %h/%h expected 0", act_a, act_b);
        end
        for (int i = 1; i <= 4; i++) begin
            run(1, 1, 2'($urandom));
            n_cmp++;
            if (o_ready_a !== (i == 3)) begin
                n_err++; $display("FAIL ready_after_reset[%0d]: got %b expected %b", i, o_ready_a, (i == 3));
            end
            n_cmp++;
            if (act_a !== exp_vec(0)) begin
                n_err++; $display("FAIL post_reset[%0d]: got %h expected %h", i, act_a, exp_vec(0));
            end
        end
    endtask

    initial begin
        i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_sym = 2'b00;
        i_coeff_we = 1'b0; i_coeff_addr = 5'd0; i_coeff_data = 8'd0;
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_underrun();
        test_enable_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_polyphase_fir.md
TX_POLYPHASE_FIR -- requirements
Module: tx_polyphase_fir

Interface
REQ-001 Parameter NB_OUTPUT, default 8: output sample width per channel.
REQ-002 Parameter NBF_OUTPUT, default 6: output fractional bits; NBF_OUTPUT <= NBF_COEFF SHALL hold.
REQ-003 Parameter NB_COEFF, default 8: coefficient width, signed.
REQ-004 Parameter NBF_COEFF, default 6: coefficient fractional bits.
REQ-005 Parameter NBAUDS, default 6: filter span in symbols.
REQ-006 Parameter OS, default 4: oversampling factor, >= 2.
REQ-007 Parameter NCH, default 2: channel count (I/Q = 2); coefficients shared by all channels.
REQ-008 clock  in  1  single clock; all logic rising-edge.
REQ-009 i_reset  in  1  reset, synchronous, active-low.
REQ-010 i_enable  in  1  advance one output phase this cycle.
REQ-011 i_valid  in  1  symbol present on i_sym at wrap cycle.
REQ-012 i_sym  in  NCH  one bit per channel; 0 maps to +1, 1 maps to -1.
REQ-013 o_ready  out  1  high when phase == OS-1 (symbol consumed this cycle if i_enable).
REQ-014 i_coeff_we  in  1  coefficient write strobe.
REQ-015 i_coeff_addr  in  clog2(NBAUDS*OS)  coefficient index n.
REQ-016 i_coeff_data  in  NB_COEFF  signed coefficient h[n].
REQ-017 o_data  out  NCH*NB_OUTPUT  signed samples, channel 0 in LSBs.
REQ-018 o_valid  out  1  o_data/o_phase updated this cycle.
REQ-019 o_phase  out  clog2(OS)  polyphase index of o_data.
REQ-020 o_underrun  out  1  sticky: wrap occurred with i_valid low.

Function
REQ-021 Phase counter p SHALL increment modulo OS on each i_enable cycle; hold when i_enable low.
REQ-022 On an i_enable cycle with p == OS-1: per channel, shift register SHALL shift in mapped i_sym if i_valid, else a zero symbol (contributes 0) and set o_underrun.
REQ-023 i_valid/i_sym ignored on any cycle that is not (i_enable and p == OS-1).
REQ-024 For i_enable cycle t at phase p: o_data_c(t+1) = Q(sum k=0..NBAUDS-1 of s_c,k * h[k*OS+p]), s_c,0 newest symbol; o_phase(t+1)=p; o_valid(t+1)=1.
REQ-025 o_valid SHALL be 0 the cycle after any cycle with i_enable low; o_data/o_phase hold.
REQ-026 Accumulator full precision: NB_COEFF+clog2(NBAUDS)+1 bits, NBF_COEFF fractional; no internal overflow.
REQ-027 Q: drop NBF_COEFF-NBF_OUTPUT LSBs with round-half-up, then saturate to [-2^(NB_OUTPUT-1), 2^(NB_OUTPUT-1)-1].
REQ-028 Coefficient write takes effect for computations on the cycle after i_coeff_we; write and enable same cycle use old h[n].
REQ-029 Writes with i_coeff_addr >= NBAUDS*OS SHALL be ignored.
REQ-030 Latency symbol-in to first dependent output: 2 cycles (shift at wrap, phase 0 computed next enabled cycle, registered).

Reset
REQ-031 While i_reset low at a clock edge: p=0, all taps zero symbols, coefficients 0, o_data=0, o_valid=0, o_phase=0, o_underrun=0, o_ready=0.
REQ-032 Reset mid-symbol SHALL discard partial phase and history; first post-reset wrap occurs after OS enabled cycles.

Structure
REQ-033 Shared package: symbol mapping constants, clog2 helper, Q-function width constants derived from parameters.
REQ-034 One sub-module tx_fir_quant (round + saturate), instantiated per channel.

Verification
REQ-035 Impulse: h[n]=n (LSB units), NBF equal, one symbol bit 0 then zeros, i_enable=1 -> o_data ch0 = 0,1,...,23 over 24 outputs, then 0.
REQ-036 Saturation: all h=0x7F, six bit-0 symbols -> 0x7F; six bit-1 symbols -> 0x80.
REQ-037 Rounding: NBF_OUTPUT=5, h[0]=0x03, impulse -> phase-0 output 0x02; h[0]=0xFD -> 0xFF.
REQ-038 Underrun: i_valid low at one wrap -> o_underrun=1 and stays 1; output equals zero-symbol response.
REQ-039 Enable gaps: random i_enable duty -> output sequence identical to continuous case, o_valid only after enabled cycles.
REQ-040 Reset at phase 2 mid-stream -> all outputs 0 next cycle; o_ready first high 4 enabled cycles later.
